// File: rtl/meta_rr_arbiter_pkg.sv
// Shared helpers for the metadata round-robin arbiter.
// Holds the width helper that both the arbiter top and its priority picker use,
// so they agree on how many bits a source index or burst count needs.
package meta_rr_arbiter_pkg;

    // Bits needed to encode the values 0..n-1; never fewer than one bit.
    function automatic int idx_bits(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/meta_rr_arbiter_pick.sv
// Rotating priority picker for the metadata arbiter (purely combinational).
// Finds the first set request bit at or after ptr, wrapping past N_SRC-1 to 0.
// Ports:
//   req  in  N_SRC    request vector, one bit per source
//   ptr  in  ID_BITS  index with highest priority (0..N_SRC-1)
//   any  out 1        at least one request bit is set
//   idx  out ID_BITS  winning index; 0 when no request is set
module meta_rr_arbiter_pick
    import meta_rr_arbiter_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int ID_BITS = idx_bits(N_SRC)
) (
    input  logic [N_SRC-1:0]   req,
    input  logic [ID_BITS-1:0] ptr,
    output logic               any,
    output logic [ID_BITS-1:0] idx
);

    // One extra bit so ptr + offset never overflows before the wrap compare.
    localparam int SUM_W = ID_BITS + 1;
    localparam logic [SUM_W-1:0] N_WRAP = SUM_W'(N_SRC);

    logic [SUM_W-1:0]   sum_s;
    logic [ID_BITS-1:0] cand_s;
    logic               found_s;

    // Scan ptr, ptr+1, ... modulo N_SRC and keep the first requesting index.
    always_comb begin
        any     = |req;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum_s = {1'b0, ptr} + SUM_W'(k);
            // Subtract rather than take a modulo so non-power-of-two N_SRC works.
            if (sum_s >= N_WRAP) begin
                cand_s = ID_BITS'(sum_s - N_WRAP);
            end else begin
                cand_s = ID_BITS'(sum_s);
            end
            if (!found_s && req[cand_s]) begin
                idx     = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/meta_rr_arbiter.sv
// Round-robin arbiter merging N_SRC metadata request streams into one stream.
// A source may keep the grant for up to MAX_BURST consecutive beats, after
// which priority moves to the next index. The output is a single registered
// slot that can drain and reload in the same cycle, giving one beat per cycle.
// Ports (all synchronous to aclk):
//   aclk          in  1                  clock
//   aresetn       in  1                  synchronous active-low reset
//   s_meta_valid  in  N_SRC              per-source valid
//   s_meta_ready  out N_SRC              per-source ready, at most one bit high
//   s_meta_data   in  N_SRC*DATA_BITS    packed per-source beats
//   m_meta_valid  out 1                  output beat valid
//   m_meta_ready  in  1                  downstream ready
//   m_meta_data   out DATA_BITS          output beat
//   m_meta_id     out ID_BITS            source index of the output beat
module meta_rr_arbiter
    import meta_rr_arbiter_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 64,
    parameter int MAX_BURST = 1,
    parameter int ID_BITS   = $clog2(N_SRC)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [N_SRC-1:0]           s_meta_valid,
    output logic [N_SRC-1:0]           s_meta_ready,
    input  logic [N_SRC*DATA_BITS-1:0] s_meta_data,
    output logic                       m_meta_valid,
    input  logic                       m_meta_ready,
    output logic [DATA_BITS-1:0]       m_meta_data,
    output logic [ID_BITS-1:0]         m_meta_id
);

    // Burst count must hold 1..MAX_BURST for the post-grant compare.
    localparam int CNT_BITS = idx_bits(MAX_BURST + 1);
    localparam logic [CNT_BITS-1:0] MAX_BURST_C = CNT_BITS'(MAX_BURST);
    localparam logic [ID_BITS-1:0]  LAST_SRC_C  = ID_BITS'(N_SRC - 1);

    logic [ID_BITS-1:0]   ptr_r;
    logic [CNT_BITS-1:0]  cnt_r;
    logic                 any_s;
    logic [ID_BITS-1:0]   win_s;
    logic                 load_ok_s;
    logic                 take_s;
    logic [DATA_BITS-1:0] win_data_s;
    logic [CNT_BITS-1:0]  burst_c_s;
    logic [CNT_BITS-1:0]  cnt_nxt_s;
    logic [ID_BITS-1:0]   ptr_nxt_s;

    meta_rr_arbiter_pick #(
        .N_SRC  (N_SRC),
        .ID_BITS(ID_BITS)
    ) u_pick (
        .req(s_meta_valid),
        .ptr(ptr_r),
        .any(any_s),
        .idx(win_s)
    );

    // Accept a beat when the slot is free or draining; never while in reset.
    always_comb begin
        load_ok_s = !m_meta_valid || m_meta_ready;
        take_s    = load_ok_s && any_s && aresetn;
    end

    // One-hot ready to the winner only; depends on valid, never on data.
    always_comb begin
        s_meta_ready = '0;
        if (take_s) begin
            s_meta_ready[win_s] = 1'b1;
        end else begin
            s_meta_ready = '0;
        end
    end

    // Select the winning source's beat from the packed input bus.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_s == ID_BITS'(i)) begin
                win_data_s = s_meta_data[i*DATA_BITS +: DATA_BITS];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Burst bookkeeping: a winner other than ptr starts a fresh burst at 1,
    // so an idle owner hands over without a bubble.
    always_comb begin
        if (win_s == ptr_r) begin
            burst_c_s = cnt_r + CNT_BITS'(1);
        end else begin
            burst_c_s = CNT_BITS'(1);
        end
        if (burst_c_s == MAX_BURST_C) begin
            cnt_nxt_s = '0;
            // Explicit wrap keeps ptr inside 0..N_SRC-1 for any N_SRC.
            if (win_s == LAST_SRC_C) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = win_s + ID_BITS'(1);
            end
        end else begin
            cnt_nxt_s = burst_c_s;
            ptr_nxt_s = win_s;
        end
    end

    // Output slot and arbitration state; ptr/cnt move only on an accepted beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_meta_valid <= 1'b0;
            m_meta_data  <= '0;
            m_meta_id    <= '0;
            ptr_r        <= '0;
            cnt_r        <= '0;
        end else if (take_s) begin
            m_meta_valid <= 1'b1;
            m_meta_data  <= win_data_s;
            m_meta_id    <= win_s;
            ptr_r        <= ptr_nxt_s;
            cnt_r        <= cnt_nxt_s;
        end else if (m_meta_ready) begin
            m_meta_valid <= 1'b0;
        end else begin
            m_meta_valid <= m_meta_valid;
        end
    end

endmodule

// File: doc/meta_rr_arbiter.md
# meta_rr_arbiter

Round-robin arbiter that merges `N_SRC` independent metadata request streams into one metadata stream. Each beat is tagged with the index of the source that produced it. It sits in front of shared RoCE metadata consumers, such as a single command queue, a DMA request port or a state-table lookup, that several protocol engines must use in turn. A configurable burst length lets a source keep the grant for up to `MAX_BURST` consecutive beats. The output is a single registered slot, so the block sustains one beat per cycle.

## Interface
- `N_SRC`, 4: number of requesting sources; must be at least 2.
- `DATA_BITS`, 64: width of one metadata beat.
- `MAX_BURST`, 1: maximum number of consecutive grants to one source before the turn passes on; must be at least 1.
- `ID_BITS`, `$clog2(N_SRC)`: derived width of the source tag; do not override.

Ports, all synchronous to `aclk`:
- `aclk`  in  1  clock; the block uses this single clock.
- `aresetn`  in  1  reset, synchronous and active-low.
- `s_meta_valid`  in  `N_SRC`  per-source valid.
- `s_meta_ready`  out  `N_SRC`  per-source ready; at most one bit is high in any cycle.
- `s_meta_data`  in  `N_SRC*DATA_BITS`  packed per-source data; source i occupies bits `[i*DATA_BITS +: DATA_BITS]`.
- `m_meta_valid`  out  1  output beat valid.
- `m_meta_ready`  in  1  downstream ready.
- `m_meta_data`  out  `DATA_BITS`  output beat.
- `m_meta_id`  out  `ID_BITS`  index of the source that produced the output beat.

## Operation
- Handshake: a transfer occurs on any side when valid and ready are both high at a rising edge of `aclk`.
- State:
  - `ptr`: the source that currently has priority, range 0..N_SRC-1.
  - `cnt`: grants already given in the current burst, range 0..MAX_BURST-1.
  - The output slot: `m_meta_valid`, `m_meta_data`, `m_meta_id`.
- Slot free: `load_ok = !m_meta_valid | m_meta_ready`.
- Winner `w`: the first index `i` with `s_meta_valid[i]` set, scanning `ptr, ptr+1, …` modulo `N_SRC`. The winner is combinational.
- Ready: `s_meta_ready[w] = load_ok & any_valid`; all other ready bits are 0. Ready may depend on valid. Ready never depends on any source's data.
- On an input transfer from `w`:
  - Load `m_meta_data` with the data of source `w` and `m_meta_id` with `w`.
  - Set `m_meta_valid` to 1.
  - Compute `c = (w == ptr) ? cnt + 1 : 1`.
  - If `c == MAX_BURST`: `ptr <= (w + 1) mod N_SRC`, `cnt <= 0`.
  - Otherwise: `ptr <= w`, `cnt <= c`.
- On an output transfer with no input transfer in the same cycle: `m_meta_valid <= 0`. `m_meta_data` and `m_meta_id` hold their values.
- With no input transfer, `ptr` and `cnt` hold their values.
- Source idle mid-burst: if the burst owner deasserts valid, the next valid source wins. Its burst starts at `c = 1`, so no bubble is inserted.
- Wrap-around: the modulo increment wraps from `N_SRC-1` to 0. For non-power-of-two `N_SRC`, the counter never takes a value of `N_SRC` or above.
- Simultaneous output drain and input load: both take effect in the same cycle, so the slot stays full at 100% throughput.
- Output stalled (`m_meta_valid=1`, `m_meta_ready=0`): all `s_meta_ready` bits are 0, and `ptr`/`cnt` are frozen.
- Sources must hold valid and data stable until accepted. The arbiter may grant a different source if a higher-priority source asserts valid first. A pending source is never starved: it is served within `(N_SRC-1)*MAX_BURST` grants.

## Timing
- Latency: 1 cycle from input acceptance to `m_meta_valid`.
- Throughput: 1 beat per cycle while downstream is ready.
- Reset values: `m_meta_valid=0`, `m_meta_data=0`, `m_meta_id=0`, `ptr=0`, `cnt=0`. `s_meta_ready` is 0 during reset.
- Reset asserted mid-operation discards the beat in the output slot. The next edge after release can accept a beat.
- No combinational path from `s_meta_valid` to `m_meta_*`. The only combinational paths are `s_meta_valid` → `s_meta_ready` and `m_meta_ready` → `s_meta_ready`.

## Structure
- No new shared typedefs. If more than one module needs the source-tag width, place the `ID_BITS` helper in `roceTypes`.
- Sub-module `meta_rr_pick`: purely combinational. Inputs: `req[N_SRC]` and `ptr`. Outputs: `any` and `idx`, the first set bit at or after `ptr` with wrap.
- Everything else lives in one module.

## Test plan
- Parameters `N_SRC=4`, `MAX_BURST=1`. All sources valid continuously, `m_meta_ready=1`. Required: ids 0,1,2,3,0,… one beat per cycle; first `m_meta_valid` one cycle after release of reset.
- Parameter `MAX_BURST=3`. Sources 1 and 2 continuously valid. Required: ids 1,1,1,2,2,2,1,…
- Parameter `MAX_BURST=4`. Only source 3 valid for 2 beats, then only source 0 valid. Required: ids 3,3,0,… with no idle cycle at the switch.
- Hold `m_meta_ready=0` for 5 cycles with the slot full. Required:
  - `s_meta_ready` is 0 throughout.
  - `m_meta_data` and `m_meta_id` are stable.
  - On release, the next beat comes from the next source in round-robin order.
- Parameter `N_SRC=3`; source 2 bursts. Required: priority wraps from 2 to 0; `ptr` never reads 3.
- Assert `aresetn=0` for 1 cycle while the slot is full and a burst is mid-way. Required: all outputs return to their reset values, and arbitration restarts at source 0.
